// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_pkg
//  Brief    : Shared Q-format constants and loader state encoding for the
//             network input loader.
//  Revision : 1.0
// ============================================================================
package nn_pkg;

    localparam int NUM_INPUTS      = 784;
    localparam int NUM_OUTPUTS     = 10;
    localparam int DATA_WIDTH      = 16;
    localparam int DATA_FRAC_WIDTH = 8;
    localparam int PIXEL_WIDTH     = 8;
    localparam int IDX_WIDTH       = $clog2(NUM_OUTPUTS);

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } loader_state_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/nn_pixel_to_fixed.sv
`default_nettype none
// ============================================================================
//  Module   : nn_pixel_to_fixed
//  Brief    : Zero-extends an unsigned pixel into the fraction field of a
//             fixed-point network input element (LSB-aligned).
//  Revision : 1.0
// ============================================================================
module nn_pixel_to_fixed
    import nn_pkg::*;
#(
    parameter int pixelWidth    = PIXEL_WIDTH,
    parameter int dataWidth     = DATA_WIDTH,
    parameter int dataFracWidth = DATA_FRAC_WIDTH
) (
    input  logic [pixelWidth-1:0] pixel_i,
    output logic [dataWidth-1:0]  fixed_o
);

    // A pixel wider than the fraction would spill into the integer bits.
    generate
        if (pixelWidth > dataFracWidth) begin : g_bad_width
            $error("nn_pixel_to_fixed: pixelWidth must not exceed dataFracWidth");
        end
    endgenerate

    assign fixed_o = dataWidth'(pixel_i);

endmodule : nn_pixel_to_fixed
`default_nettype wire

// File: rtl/nn_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : nn_frame_loader
//  Brief    : Streams pixels into the packed network input vector, starts the
//             network and captures its classification result.
//  Revision : 1.0
// ============================================================================
module nn_frame_loader
    import nn_pkg::*;
#(
    parameter int numInputs     = NUM_INPUTS,
    parameter int dataWidth     = DATA_WIDTH,
    parameter int dataFracWidth = DATA_FRAC_WIDTH,
    parameter int pixelWidth    = PIXEL_WIDTH,
    parameter int idxWidth      = IDX_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [pixelWidth-1:0]         in_data,
    input  logic                          in_sof,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [numInputs*dataWidth-1:0] NNin,
    output logic                          NNvalid,
    input  logic                          NNoutValid,
    input  logic [idxWidth-1:0]           maxIndex,
    output logic [idxWidth-1:0]           result_index,
    output logic                          result_valid,
    output logic                          busy,
    output logic                          frame_err
);

    localparam int               CNT_W    = (numInputs > 1) ? $clog2(numInputs) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(numInputs - 1);

    loader_state_t                  state_q, state_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic                           nnvalid_q, nnvalid_d;
    logic                           in_ready_q, in_ready_d;
    logic                           busy_q, busy_d;
    logic                           result_valid_q, result_valid_d;
    logic                           frame_err_q, frame_err_d;
    logic [idxWidth-1:0]            result_index_q, result_index_d;
    logic [numInputs*dataWidth-1:0] nnin_q;

    logic                           accept;
    logic                           wr_en;
    logic [CNT_W-1:0]               wr_idx;
    logic [dataWidth-1:0]           pix_fixed;

    nn_pixel_to_fixed #(
        .pixelWidth    (pixelWidth),
        .dataWidth     (dataWidth),
        .dataFracWidth (dataFracWidth)
    ) u_pixel_to_fixed (
        .pixel_i (in_data),
        .fixed_o (pix_fixed)
    );

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        nnvalid_d      = nnvalid_q;
        busy_d         = busy_q;
        result_index_d = result_index_q;
        result_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        wr_en          = 1'b0;
        wr_idx         = count_q;
        accept         = in_valid && in_ready_q;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    busy_d = 1'b1;
                    // A start-of-frame always restarts at element 0, even on what
                    // would otherwise have been the final element.
                    if (in_sof) begin
                        wr_idx      = '0;
                        count_d     = CNT_W'(1);
                        frame_err_d = (count_q != '0);
                    end else if (count_q == LAST_IDX) begin
                        count_d   = '0;
                        state_d   = RUN;
                        nnvalid_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (NNoutValid) begin
                    result_index_d = maxIndex;
                    result_valid_d = 1'b1;
                    nnvalid_d      = 1'b0;
                    busy_d         = 1'b0;
                    state_d        = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        // Ready only opens after a full cycle in LOAD, so it trails NNvalid's fall.
        in_ready_d = (state_q == LOAD) && (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= LOAD;
            count_q        <= '0;
            nnvalid_q      <= 1'b0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            result_index_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            nnvalid_q      <= nnvalid_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            frame_err_q    <= frame_err_d;
            result_index_q <= result_index_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nnin_q <= '0;
        end else if (wr_en) begin
            nnin_q[wr_idx*dataWidth +: dataWidth] <= pix_fixed;
        end
    end

    assign in_ready     = in_ready_q;
    assign NNin         = nnin_q;
    assign NNvalid      = nnvalid_q;
    assign result_index = result_index_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign frame_err    = frame_err_q;

endmodule : nn_frame_loader
`default_nettype wire

// File: tb/tb_nn_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nn_frame_loader
//  Brief    : Scoreboard bench for nn_frame_loader: directed frames, resync,
//             gapped input, async resets and result capture.
//  Revision : 1.0
// ============================================================================
module tb_nn_frame_loader;

    localparam int NIN = 784;
    localparam int DW  = 16;
    localparam int PW  = 8;
    localparam int IW  = 4;

    typedef logic [NIN*DW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    vec_t          NNin;
    logic          NNvalid;
    logic          NNoutValid = 1'b0;
    logic [IW-1:0] maxIndex = '0;
    logic [IW-1:0] result_index;
    logic          result_valid;
    logic          busy;
    logic          frame_err;

    nn_frame_loader #(
        .numInputs     (NIN),
        .dataWidth     (DW),
        .dataFracWidth (8),
        .pixelWidth    (PW),
        .idxWidth      (IW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .NNin         (NNin),
        .NNvalid      (NNvalid),
        .NNoutValid   (NNoutValid),
        .maxIndex     (maxIndex),
        .result_index (result_index),
        .result_valid (result_valid),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    vec_t          exp_frames[$];
    logic [IW-1:0] exp_results[$];
    int            ferr_seen  = 0;
    int            res_seen   = 0;
    int            beats_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int pat, input int k);
        logic [31:0] v;
        case (pat)
            0:       v = k;
            1:       v = k * 3 + 5;
            default: v = 255 - k;
        endcase
        return v[PW-1:0];
    endfunction

    function automatic vec_t frame_vec(input int pat);
        vec_t v = '0;
        for (int k = 0; k < NIN; k++) v[k*DW +: DW] = {8'h00, pix(pat, k)};
        return v;
    endfunction

    function automatic int first_diff(input vec_t a, input vec_t b);
        for (int k = 0; k < NIN; k++) if (a[k*DW +: DW] !== b[k*DW +: DW]) return k;
        return -1;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a frame or result.
    initial begin
        logic prev_nnvalid = 1'b0;
        logic unstable     = 1'b0;
        vec_t snap         = '0;
        vec_t ev;
        int   d;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) beats_seen++;
            if (frame_err) ferr_seen++;
            if (result_valid) begin
                res_seen++;
                if (exp_results.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL result_unexpected: got index %0d expected no pulse", result_index);
                end else begin
                    chk("result_index", 32'(result_index), 32'(exp_results.pop_front()));
                end
            end
            if (NNvalid && !prev_nnvalid) begin
                checks++;
                if (exp_frames.size() == 0) begin
                    errors++;
                    $display("FAIL nnin_frame: got NNvalid expected no frame");
                end else begin
                    ev = exp_frames.pop_front();
                    if (NNin !== ev) begin
                        errors++;
                        d = first_diff(NNin, ev);
                        $display("FAIL nnin_frame: element %0d got 0x%0h expected 0x%0h",
                                 d, NNin[d*DW +: DW], ev[d*DW +: DW]);
                    end
                end
                snap     = NNin;
                unstable = 1'b0;
            end else if (NNvalid && (NNin !== snap)) begin
                unstable = 1'b1;
            end
            if (!NNvalid && prev_nnvalid) chk("nnin_stable", 32'(unstable), 32'd0);
            prev_nnvalid = NNvalid;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [PW-1:0] d, input logic sof, input bit gaps);
        logic took   = 1'b0;
        int   budget = 0;
        if (gaps && ($urandom_range(0, 1) == 1)) idle(1);
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        while (!took) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!took && budget > 2000) begin
                checks++; errors++;
                $display("FAIL beat_timeout: got no in_ready expected acceptance");
                break;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(input int pat, input int lo, input int hi, input bit gaps);
        for (int k = lo; k <= hi; k++) send_beat(pix(pat, k), (k == 0), gaps);
    endtask

    task automatic finish_run(input logic [IW-1:0] idx);
        idle(20);
        NNoutValid = 1'b1;
        maxIndex   = idx;
        exp_results.push_back(idx);
        idle(1);
        NNoutValid = 1'b0;
        idle(1);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_nnvalid"},  32'(NNvalid),      32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready),     32'd0);
        chk({tag, "_busy"},     32'(busy),         32'd0);
        chk({tag, "_nnin"},     32'(NNin == '0),   32'd1);
        chk({tag, "_result"},   32'(result_index), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        logic hold_bad;
        int   base;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",     32'(in_ready),     32'd0);
        chk("rst_nnvalid",      32'(NNvalid),      32'd0);
        chk("rst_busy",         32'(busy),         32'd0);
        chk("rst_result_index", 32'(result_index), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_frame_err",    32'(frame_err),    32'd0);
        chk("rst_nnin",         32'(NNin == '0),   32'd1);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Gap-free ramp frame
        exp_frames.push_back(frame_vec(0));
        chk("busy_idle", 32'(busy), 32'd0);
        send_range(0, 0, 0, 1'b0);
        chk("busy_first_beat", 32'(busy), 32'd1);
        send_range(0, 1, NIN - 2, 1'b0);
        chk("nnvalid_before_last", 32'(NNvalid), 32'd0);
        send_range(0, NIN - 1, NIN - 1, 1'b0);
        chk("nnvalid_latency", 32'(NNvalid), 32'd1);
        chk("ready_in_run",    32'(in_ready), 32'd0);
        chk("elem255_ff",      32'(NNin[255*DW +: DW]), 32'h00FF);

        hold_bad = 1'b0;
        repeat (500) begin
            idle(1);
            if (!NNvalid || in_ready) hold_bad = 1'b1;
        end
        chk("nnvalid_hold", 32'(hold_bad), 32'd0);
        NNoutValid = 1'b1;
        maxIndex   = 4'd7;
        exp_results.push_back(4'd7);
        idle(1);
        NNoutValid = 1'b0;
        chk("done_result_valid", 32'(result_valid), 32'd1);
        chk("done_result_index", 32'(result_index), 32'd7);
        chk("done_nnvalid",      32'(NNvalid),      32'd0);
        chk("done_busy",         32'(busy),         32'd0);
        chk("done_ready_low",    32'(in_ready),     32'd0);
        idle(1);
        chk("done_pulse_once",   32'(result_valid), 32'd0);
        chk("done_ready_high",   32'(in_ready),     32'd1);

        // Network result while loading must be ignored
        NNoutValid = 1'b1;
        maxIndex   = 4'd3;
        idle(1);
        NNoutValid = 1'b0;
        idle(2);
        chk("load_ignore_index", 32'(result_index), 32'd7);
        chk("load_ignore_count", 32'(res_seen),     32'd1);

        // Resynchronisation after 300 beats
        base = ferr_seen;
        send_range(2, 0, 299, 1'b0);
        chk("no_err_clean_sof", 32'(ferr_seen - base), 32'd0);
        v = frame_vec(1);
        v[0 +: DW] = 16'h00AA;
        exp_frames.push_back(v);
        send_beat(8'hAA, 1'b1, 1'b0);
        chk("resync_frame_err", 32'(frame_err), 32'd1);
        send_range(1, 1, NIN - 2, 1'b0);
        chk("resync_no_run_early", 32'(NNvalid), 32'd0);
        chk("resync_err_once",     32'(ferr_seen - base), 32'd1);
        send_range(1, NIN - 1, NIN - 1, 1'b0);
        chk("resync_run", 32'(NNvalid), 32'd1);
        finish_run(4'd5);

        // sof on what would be the last element restarts the frame
        send_range(1, 0, NIN - 2, 1'b0);
        v = frame_vec(0);
        v[0 +: DW] = 16'h005C;
        exp_frames.push_back(v);
        send_beat(8'h5C, 1'b1, 1'b0);
        chk("sof_last_err", 32'(frame_err), 32'd1);
        idle(1);
        chk("sof_last_no_run", 32'(NNvalid), 32'd0);
        send_range(0, 1, NIN - 1, 1'b0);
        chk("sof_last_run", 32'(NNvalid), 32'd1);
        finish_run(4'd9);

        // Randomly gapped frame
        base = beats_seen;
        exp_frames.push_back(frame_vec(0));
        send_range(0, 0, NIN - 1, 1'b1);
        chk("gapped_beats", 32'(beats_seen - base), 32'd784);
        finish_run(4'd2);

        // Reset mid-frame, then a normal frame
        send_range(1, 0, 399, 1'b0);
        async_reset("rst_midframe");
        exp_frames.push_back(frame_vec(0));
        send_range(0, 0, NIN - 1, 1'b0);
        finish_run(4'd4);

        // Reset during RUN, then a normal frame
        exp_frames.push_back(frame_vec(2));
        send_range(2, 0, NIN - 1, 1'b0);
        idle(10);
        async_reset("rst_run");
        exp_frames.push_back(frame_vec(1));
        send_range(1, 0, NIN - 1, 1'b0);
        finish_run(4'd6);

        idle(5);
        chk("frames_left",   32'(exp_frames.size()),  32'd0);
        chk("results_left",  32'(exp_results.size()), 32'd0);
        chk("results_total", 32'(res_seen),           32'd6);
        chk("frame_err_total", 32'(ferr_seen),        32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nn_frame_loader
`default_nettype wire
